// File: rtl/ip_codma_wr_engine.sv
// ip_codma_wr_engine: parametrised CoDMA burst write engine (descriptor -> req/grant -> valid/ready beats).
// Define CODMA_WR_TIMEOUT_EN to add a watchdog that aborts a stalled ASK/DATA phase with an error.
module ip_codma_wr_engine #(
    parameter int DATA_W         = 64,
    parameter int ADDR_W         = 32,
    parameter int MAX_BEATS      = 16,
    parameter int BEAT_W         = $clog2(MAX_BEATS + 1),
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [BEAT_W-1:0] beats_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    output logic              bus_req_o,
    input  logic              bus_grant_i,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic              bus_wvalid_o,
    input  logic              bus_wready_i,
    output logic              bus_last_o,
    input  logic              bus_error_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [BEAT_W-1:0] beat_count_o
);
    typedef enum logic [2:0] {IDLE = 3'd0, ASK = 3'd1, DATA = 3'd2, DONE = 3'd3, ERR = 3'd4} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BEAT_W-1:0]   len_q, len_d;
    logic [BEAT_W-1:0]   count_q, count_d;
    logic                error_q, error_d;
    logic                in_bus, accept, last, start_acc, illegal, timeout;

    always_comb begin
        in_bus    = (state_q == ASK) || (state_q == DATA);
        accept    = (state_q == DATA) && wr_valid_i && bus_wready_i;
        last      = (state_q == DATA) && (count_q == len_q - BEAT_W'(1));
        start_acc = (state_q == IDLE) && start_i;
        illegal   = !(state_q inside {IDLE, ASK, DATA, DONE, ERR});
    end

`ifdef CODMA_WR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    // A beat in the timeout cycle wins, so a slow-but-alive bus never errors.
    always_comb begin
        timeout = in_bus && !accept && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
        tmo_d   = ((state_d == ASK) && (state_q != ASK)) || accept ? '0 :
                  in_bus ? tmo_q + TW'(1) : tmo_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) tmo_q <= '0;
        else            tmo_q <= tmo_d;
    end
`else
    always_comb timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_i && state_q != IDLE)  state_d = IDLE;
        else if (bus_error_i && in_bus) state_d = ERR;
        else if (timeout)               state_d = ERR;
        else begin
            case (state_q)
                IDLE:      if (start_i) state_d = (beats_i == '0) ? DONE :
                                                  (beats_i > BEAT_W'(MAX_BEATS)) ? ERR : ASK;
                ASK:       if (bus_grant_i) state_d = DATA;
                DATA:      if (accept && last) state_d = DONE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // A beat coinciding with a bus error is not counted.
    always_comb begin
        addr_d  = start_acc ? addr_i :
                  (accept && !bus_error_i) ? addr_q + ADDR_W'(DATA_W / 8) : addr_q;
        len_d   = start_acc ? beats_i : len_q;
        count_d = start_acc ? '0 : (accept && !bus_error_i) ? count_q + BEAT_W'(1) : count_q;
        error_d = (state_d == ERR || (illegal && !stop_i)) ? 1'b1 : start_acc ? 1'b0 : error_q;
    end

    always_comb begin
        bus_req_o    = in_bus;
        wr_ready_o   = (state_q == DATA) && bus_wready_i;
        bus_wvalid_o = (state_q == DATA) && wr_valid_i;
        bus_wdata_o  = (state_q == DATA) ? wr_data_i : '0;
        bus_last_o   = last;
        bus_addr_o   = addr_q;
        busy_o       = state_q != IDLE;
        done_o       = (state_q == DONE) || (state_q == ERR);
        error_o      = error_q;
        beat_count_o = count_q;
    end
endmodule

// File: tb/tb_ip_codma_wr_engine.sv
// tb_ip_codma_wr_engine: directed-vector bench for ip_codma_wr_engine (64-bit data, 16-beat max).
module tb_ip_codma_wr_engine;
    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        start_i, stop_i;
    logic [31:0] addr_i;
    logic [4:0]  beats_i;
    logic [63:0] wr_data_i;
    logic        wr_valid_i, wr_ready_o;
    logic        bus_req_o, bus_grant_i;
    logic [31:0] bus_addr_o;
    logic [63:0] bus_wdata_o;
    logic        bus_wvalid_o, bus_wready_i, bus_last_o, bus_error_i;
    logic        busy_o, done_o, error_o;
    logic [4:0]  beat_count_o;
    int          n_chk = 0, n_pass = 0;

    ip_codma_wr_engine #(.DATA_W(64), .ADDR_W(32), .MAX_BEATS(16), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .stop_i(stop_i),
        .addr_i(addr_i), .beats_i(beats_i), .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i),
        .wr_ready_o(wr_ready_o), .bus_req_o(bus_req_o), .bus_grant_i(bus_grant_i),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_wvalid_o(bus_wvalid_o),
        .bus_wready_i(bus_wready_i), .bus_last_o(bus_last_o), .bus_error_i(bus_error_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .beat_count_o(beat_count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    endtask

    task automatic start_burst(input logic [31:0] a, input logic [4:0] b, input logic g);
        @(negedge clk_i);
        start_i = 1'b1; addr_i = a; beats_i = b; bus_grant_i = g;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("req_after_start", bus_req_o, 1'b1);
    endtask

    initial begin
        logic v, r;
        int   n;
        reset_n_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; addr_i = '0; beats_i = '0;
        wr_data_i = 64'hDEAD; wr_valid_i = 1'b0; bus_grant_i = 1'b0; bus_wready_i = 1'b0;
        bus_error_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_req", bus_req_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", error_o, 1'b0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_wdata", bus_wdata_o, 64'h0);
        reset_n_i = 1'b1;

        // reset asserted in the middle of DATA
        wr_valid_i = 1'b1; bus_wready_i = 1'b1; wr_data_i = 64'hFF;
        start_burst(32'h40, 5'd4, 1'b1);
        @(negedge clk_i);
        chk("pre_rst_wvalid", bus_wvalid_o, 1'b1);
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_req", bus_req_o, 1'b0);
        chk("mid_rst_wvalid", bus_wvalid_o, 1'b0);
        chk("mid_rst_wready", wr_ready_o, 1'b0);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_addr", bus_addr_o, 32'h0);
        chk("mid_rst_wdata", bus_wdata_o, 64'h0);
        chk("mid_rst_cnt", beat_count_o, 5'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // 4-beat burst, grant in the second ASK cycle
        start_burst(32'h1000, 5'd4, 1'b0);
        chk("ask_addr", bus_addr_o, 32'h1000);
        chk("ask_wvalid", bus_wvalid_o, 1'b0);
        chk("ask_wready", wr_ready_o, 1'b0);
        @(negedge clk_i);
        chk("ask2_req", bus_req_o, 1'b1);
        bus_grant_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            wr_data_i = 64'hA0 + 64'(i);
            #1;
            chk("b1_addr", bus_addr_o, 32'h1000 + 32'(8 * i));
            chk("b1_wdata", bus_wdata_o, 64'hA0 + 64'(i));
            chk("b1_last", bus_last_o, i == 3);
            chk("b1_cnt", beat_count_o, 5'(i));
            chk("b1_done", done_o, 1'b0);
        end
        @(negedge clk_i);
        wr_valid_i = 1'b0;
        chk("b1_done_pulse", done_o, 1'b1);
        chk("b1_cnt_end", beat_count_o, 5'd4);
        chk("b1_err", error_o, 1'b0);
        chk("b1_req_off", bus_req_o, 1'b0);
        @(negedge clk_i);
        chk("b1_done_once", done_o, 1'b0);
        chk("b1_idle", busy_o, 1'b0);

        // 3 beats under valid/ready stalls
        start_burst(32'h2000, 5'd3, 1'b1);
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clk_i);
            v = (c % 2) == 0; r = (c % 3) != 2;
            wr_valid_i = v; bus_wready_i = r; wr_data_i = 64'hB0 + 64'(n);
            #1;
            chk("b2_wready", wr_ready_o, r);
            chk("b2_wvalid", bus_wvalid_o, v);
            chk("b2_addr", bus_addr_o, 32'h2000 + 32'(8 * n));
            chk("b2_cnt", beat_count_o, 5'(n));
            chk("b2_done", done_o, 1'b0);
            if (v && r) n++;
        end
        chk("b2_beats", 64'(n), 64'd3);
        @(negedge clk_i);
        wr_valid_i = 1'b0; bus_wready_i = 1'b1;
        chk("b2_done_pulse", done_o, 1'b1);
        chk("b2_cnt_end", beat_count_o, 5'd3);

        // bus error on beat 2 of 5
        wr_valid_i = 1'b1;
        start_burst(32'h3000, 5'd5, 1'b1);
        @(negedge clk_i);
        @(negedge clk_i);
        bus_error_i = 1'b1;
        chk("b3_cnt_before", beat_count_o, 5'd1);
        @(negedge clk_i);
        bus_error_i = 1'b0; wr_valid_i = 1'b0;
        chk("b3_err", error_o, 1'b1);
        chk("b3_done", done_o, 1'b1);
        chk("b3_cnt", beat_count_o, 5'd1);
        @(negedge clk_i);
        chk("b3_done_once", done_o, 1'b0);
        repeat (3) @(negedge clk_i);
        chk("b3_err_held", error_o, 1'b1);
        start_burst(32'h3100, 5'd1, 1'b1);
        chk("b3_err_clr", error_o, 1'b0);
        wr_valid_i = 1'b1;
        @(negedge clk_i);
        chk("b3_last", bus_last_o, 1'b1);
        @(negedge clk_i);
        wr_valid_i = 1'b0;
        chk("b3_done2", done_o, 1'b1);
        chk("b3_err2", error_o, 1'b0);

        // stop in ASK
        start_burst(32'h4000, 5'd4, 1'b0);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        chk("s1_req", bus_req_o, 1'b0);
        chk("s1_busy", busy_o, 1'b0);
        chk("s1_done", done_o, 1'b0);
        chk("s1_err", error_o, 1'b0);
        // stop in DATA after two beats
        wr_valid_i = 1'b1;
        start_burst(32'h4100, 5'd4, 1'b1);
        repeat (3) @(negedge clk_i);
        stop_i = 1'b1; wr_valid_i = 1'b0;
        chk("s2_cnt", beat_count_o, 5'd2);
        @(negedge clk_i);
        stop_i = 1'b0;
        chk("s2_req", bus_req_o, 1'b0);
        chk("s2_busy", busy_o, 1'b0);
        chk("s2_done", done_o, 1'b0);
        chk("s2_err", error_o, 1'b0);
        @(negedge clk_i);
        chk("s2_done_late", done_o, 1'b0);

        // zero-length and oversize descriptors
        @(negedge clk_i);
        start_i = 1'b1; beats_i = 5'd0; bus_grant_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("z_done", done_o, 1'b1);
        chk("z_req", bus_req_o, 1'b0);
        @(negedge clk_i);
        chk("z_done_once", done_o, 1'b0);
        chk("z_req2", bus_req_o, 1'b0);
        start_i = 1'b1; beats_i = 5'd17;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("o_err", error_o, 1'b1);
        chk("o_done", done_o, 1'b1);
        chk("o_req", bus_req_o, 1'b0);
        @(negedge clk_i);
        chk("o_err_held", error_o, 1'b0 | 1'b1);
        chk("o_req2", bus_req_o, 1'b0);

        // grant never given
        start_burst(32'h5000, 5'd2, 1'b0);
`ifdef CODMA_WR_TIMEOUT_EN
        repeat (7) @(negedge clk_i);
        chk("t_req_8", bus_req_o, 1'b1);
        chk("t_done_8", done_o, 1'b0);
        @(negedge clk_i);
        chk("t_done", done_o, 1'b1);
        chk("t_err", error_o, 1'b1);
`else
        n = 0;
        repeat (1000) begin
            @(negedge clk_i);
            if (done_o) n++;
        end
        chk("nt_done_count", 64'(n), 64'd0);
        chk("nt_req", bus_req_o, 1'b1);
        chk("nt_busy", busy_o, 1'b1);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        chk("nt_stop", busy_o, 1'b0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
